int_to_ascii_tx: RTL

//  Downstream of the digit concatenator: takes the finished integer result and its one-cycle done

---
 rtl/int_to_ascii_tx_if.sv | 37 +++
 rtl/int_to_ascii_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/int_to_ascii_tx_if.sv
// Byte-stream link between the integer producer, the ASCII converter and the UART transmitter.
// Master is the converter; slave is the environment (producer + UART) seen from outside.

// Handshake semantics (both are strobes, not levels):
//   res_done : one-cycle valid for resultado; honoured only while busy=0, ignored otherwise.
//   tx_start : one-cycle valid for tx_data; tx_data is held from tx_start until tx_done, and
//              no new tx_start is issued while a byte is outstanding.
//   tx_done  : one-cycle ready/ack from the UART closing the outstanding byte; ignored otherwise.
//   busy     : high from the cycle after an accepted res_done until the cycle after the last ack.
interface int_to_ascii_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] resultado;
  logic              res_done;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;

  modport master (
    input  resultado,
    input  res_done,
    input  tx_done,
    output tx_data,
    output tx_start,
    output busy
  );

  modport slave (
    output resultado,
    output res_done,
    output tx_done,
    input  tx_data,
    input  tx_start,
    input  busy
  );
endinterface

// File: rtl/int_to_ascii_tx.sv
// Converts a finished integer to ASCII decimal (optional '-', MSD first, optional CR LF)
// and streams it to a UART transmitter one byte at a time over a start/done handshake.
module int_to_ascii_tx #(
  parameter int DATA_W       = 32,
  parameter int SIGNED       = 1,
  parameter int SEND_NEWLINE = 1,
  parameter int MAX_DIGITS   = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  int_to_ascii_tx_if.master        bus,
  output logic [2:0]               state_dbg
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_SIGN = 3'd2,
    S_DIG  = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  value;
  logic [3:0]         rem;
  logic [BIT_W-1:0]   bit_cnt;
  logic               neg;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   dig_idx;
  logic               pending;
  logic [3:0]         digits [MAX_DIGITS];

  logic               is_neg;
  logic [DATA_W-1:0]  magnitude;
  logic [4:0]         rem_shift;
  logic               rem_ge10;
  logic [3:0]         rem_next;
  logic [DATA_W-1:0]  value_next;
  logic               div_last;
  logic [3:0]         cur_digit;
  logic [7:0]         next_byte;

  assign state_dbg = state;

  // Input capture: two's complement negate; the most negative value maps to its own bit pattern,
  // which read as unsigned is the correct magnitude.
  always_comb begin
    is_neg    = (SIGNED != 0) && bus.resultado[DATA_W-1];
    magnitude = is_neg ? (~bus.resultado + 1'b1) : bus.resultado;
  end

  // One restoring-division step: shift the next dividend bit into the partial remainder,
  // subtract 10 when it fits, and shift the quotient bit into the bottom of value.
  always_comb begin
    rem_shift  = {rem, value[DATA_W-1]};
    rem_ge10   = (rem_shift >= 5'd10);
    rem_next   = rem_ge10 ? 4'(rem_shift - 5'd10) : rem_shift[3:0];
    value_next = {value[DATA_W-2:0], rem_ge10};
    div_last   = (state == S_DIV) && (bit_cnt == BIT_W'(DATA_W - 1));
  end

  always_comb begin
    cur_digit = digits[dig_idx];
    unique case (state)
      S_SIGN:  next_byte = 8'h2D;
      S_DIG:   next_byte = {4'h3, cur_digit};
      S_CR:    next_byte = 8'h0D;
      S_LF:    next_byte = 8'h0A;
      default: next_byte = 8'h00;
    endcase
  end

  // Digit buffer needs no reset: it is only read back after being written by this conversion.
  always_ff @(posedge clk) begin
    if (div_last) begin
      digits[count] <= rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      value       <= '0;
      rem         <= '0;
      bit_cnt     <= '0;
      neg         <= 1'b0;
      count       <= '0;
      dig_idx     <= '0;
      pending     <= 1'b0;
      bus.tx_data <= 8'h00;
      bus.tx_start <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.res_done) begin
            neg      <= is_neg;
            value    <= magnitude;
            rem      <= '0;
            bit_cnt  <= '0;
            count    <= '0;
            pending  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= S_DIV;
          end
        end

        S_DIV: begin
          value   <= value_next;
          rem     <= rem_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (div_last) begin
            count   <= count + 1'b1;
            rem     <= '0;
            bit_cnt <= '0;
            if (value_next == '0) begin
              dig_idx <= count;
              state   <= neg ? S_SIGN : S_DIG;
            end
          end
        end

        S_SIGN, S_DIG, S_CR, S_LF: begin
          if (!pending) begin
            bus.tx_data  <= next_byte;
            bus.tx_start <= 1'b1;
            pending      <= 1'b1;
          end else if (bus.tx_done && !bus.tx_start) begin
            // An ack coinciding with our own start pulse cannot belong to this byte.
            pending <= 1'b0;
            unique case (state)
              S_SIGN: state <= S_DIG;
              S_DIG: begin
                if (dig_idx != '0) begin
                  dig_idx <= dig_idx - 1'b1;
                end else if (SEND_NEWLINE != 0) begin
                  state <= S_CR;
                end else begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
                end
              end
              S_CR: state <= S_LF;
              default: begin
                state    <= S_IDLE;
                bus.busy <= 1'b0;
              end
            endcase
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
